// File: rtl/clock_set_controller.sv
`default_nettype none
// ============================================================================
// Module      : clock_set_controller
// Description : Time-set sequencer for the binary clock. Debounces the raw
//               mode/increment push-buttons and walks RUN -> SET_HR ->
//               SET_MIN -> COMMIT, editing hour/minute values, holding the
//               clock while editing and strobing a parallel load on commit.
//               The field being edited blinks via per-field blank enables.
// Ports       :
//   clk_100MHz  in   system clock
//   reset_n     in   asynchronous active-low reset
//   btn_mode    in   raw mode button (async, active-high)
//   btn_inc     in   raw increment button (async, active-high)
//   cur_hr      in   [3:0] current hour from the clock counter (1..12)
//   cur_min     in   [5:0] current minute from the clock counter (0..59)
//   set_active  out  high in every state except RUN (clock must pause)
//   load_time   out  one-cycle strobe: clock loads set_hr/set_min
//   set_hr      out  [3:0] edited hour (1..12)
//   set_min     out  [5:0] edited minute (0..59)
//   blink_hr    out  blank the hour digits this phase
//   blink_min   out  blank the minute digits this phase
// Revision    : 1.0 - initial release
// ============================================================================
module clock_set_controller #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_CYCLES    = 25_000_000
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [3:0] cur_hr,
    input  logic [5:0] cur_min,
    output logic       set_active,
    output logic       load_time,
    output logic [3:0] set_hr,
    output logic [5:0] set_min,
    output logic       blink_hr,
    output logic       blink_min
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int BL_W = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLINK_CYCLES - 1);

    localparam logic [1:0] S_RUN     = 2'd0;
    localparam logic [1:0] S_SET_HR  = 2'd1;
    localparam logic [1:0] S_SET_MIN = 2'd2;
    localparam logic [1:0] S_COMMIT  = 2'd3;

    // ------------------------------------------------------------------
    // Button conditioning. Index 0 = mode, index 1 = inc.
    // ------------------------------------------------------------------
    logic [1:0]      w_btn_raw;
    logic [1:0]      sync1_q;
    logic [1:0]      sync2_q;
    logic [1:0]      level_q;
    logic [1:0]      level_prev_q;
    logic [1:0]      press_q;
    logic [DB_W-1:0] db_cnt_q [2];

    assign w_btn_raw = {btn_inc, btn_mode};

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            press_q      <= '0;
            for (int b = 0; b < 2; b++) begin
                db_cnt_q[b] <= '0;
            end
        end else begin
            sync1_q      <= w_btn_raw;
            sync2_q      <= sync1_q;
            level_prev_q <= level_q;
            // Press is taken from the registered debounced level, so it
            // lands one cycle after the level itself updates.
            press_q      <= level_q & ~level_prev_q;
            for (int b = 0; b < 2; b++) begin
                if (sync2_q[b] != level_q[b]) begin
                    if (db_cnt_q[b] == DB_MAX) begin
                        level_q[b]  <= sync2_q[b];
                        db_cnt_q[b] <= '0;
                    end else begin
                        db_cnt_q[b] <= db_cnt_q[b] + 1'b1;
                    end
                end else begin
                    db_cnt_q[b] <= '0;
                end
            end
        end
    end

    logic w_mode_press;
    logic w_inc_press;
    assign w_mode_press = press_q[0];
    assign w_inc_press  = press_q[1];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    logic [1:0] state_q, state_d;
    logic [3:0] hr_q, hr_d;
    logic [5:0] min_q, min_d;
    logic       w_blink_clr;

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_RUN;
            hr_q    <= 4'd12;
            min_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            hr_q    <= hr_d;
            min_q   <= min_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. Mode always beats a coincident inc press.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        hr_d        = hr_q;
        min_d       = min_q;
        w_blink_clr = 1'b0;
        case (state_q)
            S_RUN: begin
                if (w_mode_press) begin
                    state_d     = S_SET_HR;
                    w_blink_clr = 1'b1;
                    hr_d        = (cur_hr == 4'd0 || cur_hr > 4'd12) ? 4'd12 : cur_hr;
                    min_d       = (cur_min > 6'd59) ? 6'd0 : cur_min;
                end
            end
            S_SET_HR: begin
                if (w_mode_press) begin
                    state_d     = S_SET_MIN;
                    w_blink_clr = 1'b1;
                end else if (w_inc_press) begin
                    hr_d        = (hr_q == 4'd12) ? 4'd1 : hr_q + 4'd1;
                    w_blink_clr = 1'b1;
                end
            end
            S_SET_MIN: begin
                if (w_mode_press) begin
                    state_d = S_COMMIT;
                end else if (w_inc_press) begin
                    min_d       = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                    w_blink_clr = 1'b1;
                end
            end
            S_COMMIT: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Blink timebase; restarted so a freshly edited field shows at once.
    // ------------------------------------------------------------------
    logic [BL_W-1:0] blink_cnt_q;
    logic            blink_phase_q;

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (w_blink_clr) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == BL_MAX) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q   <= blink_cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs, decoded from registered state only
    // ------------------------------------------------------------------
    always_comb begin
        set_active = (state_q != S_RUN);
        load_time  = (state_q == S_COMMIT);
        set_hr     = hr_q;
        set_min    = min_q;
        blink_hr   = (state_q == S_SET_HR) & blink_phase_q;
        blink_min  = (state_q == S_SET_MIN) & blink_phase_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_clock_set_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_set_controller
// Description : Self-checking bench for clock_set_controller with short
//               debounce/blink periods. Expected load transactions are queued
//               when the commit press is driven and popped by a monitor when
//               the DUT strobes load_time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_set_controller;

    localparam int DEB = 4;
    localparam int BLK = 8;

    logic       r_clk = 1'b0;
    logic       r_rst_n;
    logic       r_btn_mode;
    logic       r_btn_inc;
    logic [3:0] r_cur_hr;
    logic [5:0] r_cur_min;
    logic       w_set_active;
    logic       w_load_time;
    logic [3:0] w_set_hr;
    logic [5:0] w_set_min;
    logic       w_blink_hr;
    logic       w_blink_min;

    always #5 r_clk = ~r_clk;

    clock_set_controller #(
        .DEBOUNCE_CYCLES (DEB),
        .BLINK_CYCLES    (BLK)
    ) u_dut (
        .clk_100MHz (r_clk),
        .reset_n    (r_rst_n),
        .btn_mode   (r_btn_mode),
        .btn_inc    (r_btn_inc),
        .cur_hr     (r_cur_hr),
        .cur_min    (r_cur_min),
        .set_active (w_set_active),
        .load_time  (w_load_time),
        .set_hr     (w_set_hr),
        .set_min    (w_set_min),
        .blink_hr   (w_blink_hr),
        .blink_min  (w_blink_min)
    );

    typedef struct packed {
        logic [3:0] hr;
        logic [5:0] min;
    } load_t;

    load_t      exp_load_q [$];
    load_t      r_mon_exp;
    int         n_cmp   = 0;
    int         n_err   = 0;
    int         n_loads = 0;
    logic [3:0] exp_hr;
    logic [5:0] exp_min;

    task automatic check(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge r_clk);
    endtask

    // Raise a button at a negedge; returns 8 negedges later, the first
    // sample point after the FSM has registered the press.
    task automatic press(input bit is_inc);
        if (is_inc) r_btn_inc = 1'b1;
        else        r_btn_mode = 1'b1;
        tick(8);
    endtask

    task automatic release_btns();
        r_btn_mode = 1'b0;
        r_btn_inc  = 1'b0;
        tick(10);
    endtask

    // Scoreboard side: every load strobe must match a queued expectation.
    always @(negedge r_clk) begin
        if (r_rst_n === 1'b1 && w_load_time) begin
            n_loads++;
            if (exp_load_q.size() == 0) begin
                check("load_unexpected", 1, 0);
            end else begin
                r_mon_exp = exp_load_q.pop_front();
                check("load_hr", int'(w_set_hr), int'(r_mon_exp.hr));
                check("load_min", int'(w_set_min), int'(r_mon_exp.min));
                check("load_active", int'(w_set_active), 1);
            end
        end
    end

    initial begin
        bit seen;
        bit prev;
        bit found;

        r_rst_n    = 1'b1;
        r_btn_mode = 1'b0;
        r_btn_inc  = 1'b0;
        r_cur_hr   = 4'd11;
        r_cur_min  = 6'd58;

        // Reset asserted mid-cycle: outputs take RUN values at once.
        #2 r_rst_n = 1'b0;
        #1;
        check("rst_active", int'(w_set_active), 0);
        check("rst_load", int'(w_load_time), 0);
        check("rst_hr", int'(w_set_hr), 12);
        check("rst_min", int'(w_set_min), 0);
        check("rst_blink", int'({w_blink_hr, w_blink_min}), 0);
        tick(3);
        r_rst_n = 1'b1;

        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick(1);
            if (w_set_active || w_load_time) seen = 1'b1;
        end
        check("idle_run", int'(seen), 0);

        // Bouncing mode button must never be accepted.
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            r_btn_mode = (i % 2 == 0);
            for (int j = 0; j < 2; j++) begin
                tick(1);
                if (w_set_active) seen = 1'b1;
            end
        end
        check("bounce_quiet", int'(seen), 0);

        // Final clean edge: press after 7 cycles, SET_HR visible at 8.
        r_btn_mode = 1'b1;
        tick(7);
        check("mode_lat_pre", int'(w_set_active), 0);
        tick(1);
        check("mode_lat_post", int'(w_set_active), 1);
        exp_hr  = 4'd11;
        exp_min = 6'd58;
        check("cap_hr", int'(w_set_hr), int'(exp_hr));
        check("cap_min", int'(w_set_min), int'(exp_min));
        check("cap_blink_hr", int'(w_blink_hr), 0);
        release_btns();

        for (int k = 0; k < 2; k++) begin
            press(1'b1);
            exp_hr = (exp_hr == 4'd12) ? 4'd1 : exp_hr + 4'd1;
            check("inc_hr", int'(w_set_hr), int'(exp_hr));
            release_btns();
        end

        press(1'b0);
        check("to_min_active", int'(w_set_active), 1);
        check("to_min_hr", int'(w_set_hr), int'(exp_hr));
        release_btns();

        for (int k = 0; k < 3; k++) begin
            press(1'b1);
            exp_min = (exp_min == 6'd59) ? 6'd0 : exp_min + 6'd1;
            check("inc_min", int'(w_set_min), int'(exp_min));
            check("inc_min_hr", int'(w_set_hr), int'(exp_hr));
            release_btns();
        end

        exp_load_q.push_back(load_t'{hr: exp_hr, min: exp_min});
        press(1'b0);
        check("commit_load", int'(w_load_time), 1);
        tick(1);
        check("post_commit_active", int'(w_set_active), 0);
        check("post_commit_load", int'(w_load_time), 0);
        check("loads_after_commit", n_loads, 1);
        release_btns();
        check("run_hold_hr", int'(w_set_hr), 1);
        check("run_hold_min", int'(w_set_min), 1);

        // Inc in RUN is ignored.
        press(1'b1);
        check("run_inc_active", int'(w_set_active), 0);
        check("run_inc_hr", int'(w_set_hr), 1);
        release_btns();

        // Out-of-range capture.
        r_cur_hr  = 4'd0;
        r_cur_min = 6'd63;
        press(1'b0);
        exp_hr  = 4'd12;
        exp_min = 6'd0;
        check("oor_hr", int'(w_set_hr), int'(exp_hr));
        check("oor_min", int'(w_set_min), int'(exp_min));
        check("oor_active", int'(w_set_active), 1);
        release_btns();

        // Simultaneous mode + inc in SET_HR: mode wins.
        r_btn_mode = 1'b1;
        r_btn_inc  = 1'b1;
        tick(8);
        check("simul_hr", int'(w_set_hr), int'(exp_hr));
        check("simul_active", int'(w_set_active), 1);
        tick(7);
        check("blink_min_ph0", int'(w_blink_min), 0);
        tick(1);
        check("blink_min_ph1", int'(w_blink_min), 1);
        check("blink_hr_off", int'(w_blink_hr), 0);
        tick(8);
        check("blink_min_ph2", int'(w_blink_min), 0);
        release_btns();

        // Inc press during a blank phase restores the field immediately.
        found = 1'b0;
        prev  = w_blink_min;
        for (int g = 0; g < 64 && !found; g++) begin
            tick(1);
            if (prev && !w_blink_min) found = 1'b1;
            prev = w_blink_min;
        end
        check("blink_fall_found", int'(found), 1);
        tick(2);
        r_btn_inc = 1'b1;
        tick(7);
        check("blink_before_inc", int'(w_blink_min), 1);
        tick(1);
        check("blink_after_inc", int'(w_blink_min), 0);
        exp_min = (exp_min == 6'd59) ? 6'd0 : exp_min + 6'd1;
        check("blink_inc_min", int'(w_set_min), int'(exp_min));
        release_btns();

        // Abort mid-edit with reset: no load, back to RUN values.
        @(posedge r_clk);
        #2 r_rst_n = 1'b0;
        #1;
        check("abort_active", int'(w_set_active), 0);
        check("abort_hr", int'(w_set_hr), 12);
        check("abort_min", int'(w_set_min), 0);
        check("abort_blink", int'(w_blink_min), 0);
        tick(2);
        r_rst_n = 1'b1;
        tick(30);
        check("abort_run", int'(w_set_active), 0);
        check("abort_loads", n_loads, 1);
        check("queue_empty", exp_load_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
